// File: rtl/rtm_wr_arb_pkg.sv
// Shared constants and arbiter state encoding for the RTM write-port arbiter.
// Slice geometry (S, R, RTM_DEPTH) is common to all RTM users in the codebase.
package rtm_wr_arb_pkg;

  localparam int S         = 4;
  localparam int R         = 2;
  localparam int RTM_DEPTH = 1024;
  localparam int RTM_AW    = $clog2(RTM_DEPTH);
  localparam int RTM_DW    = S * R * 8;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Next round-robin base after index idx finishes, wrapping at n.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rtm_wr_arb_if.sv
// Requester beat bundle plus the registered RTM write-port bundle.
// The master side is the requesters and RTM sink; the arbiter is the slave.
interface rtm_wr_arb_if #(
  parameter int NREQ = 2,
  parameter int SW   = 4,
  parameter int AW   = 10,
  parameter int DW   = 64
);
  logic [NREQ-1:0]       req_vld;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*SW-1:0]    req_en;
  logic [NREQ*SW*AW-1:0] req_addr;
  logic [NREQ*DW-1:0]    req_din;

  logic                  rtm_wr_vld;
  logic [SW-1:0]         rtm_wr_en;
  logic [SW*AW-1:0]      rtm_wr_addr;
  logic [DW-1:0]         rtm_din;

  modport master (
    output req_vld, req_last, req_en, req_addr, req_din,
    input  req_rdy, rtm_wr_vld, rtm_wr_en, rtm_wr_addr, rtm_din
  );

  modport slave (
    input  req_vld, req_last, req_en, req_addr, req_din,
    output req_rdy, rtm_wr_vld, rtm_wr_en, rtm_wr_addr, rtm_din
  );
endinterface

// File: rtl/rtm_wr_arb_rr_pick.sv
// Rotating priority encoder: one-hot grant to the first set request at or after base.
// Purely combinational so other arbiters can reuse it with their own pointer.
module rtm_wr_arb_rr_pick #(
  parameter int N  = 2,
  parameter int BW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [BW-1:0] base,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic [N-1:0] rot_s;
  logic [N-1:0] pick_s;

  // Rotate so base sits at bit 0, isolate the lowest set bit, rotate back.
  assign rot_s  = N'({req, req} >> base);
  assign pick_s = rot_s & (~rot_s + {{(N-1){1'b0}}, 1'b1});
  assign gnt    = N'(({pick_s, pick_s} << base) >> N);
  assign any    = |req;

endmodule

// File: rtl/rtm_wr_arb.sv
// Round-robin, burst-locked arbiter sharing the RTM write port between engines.
// A grant is held until the owner's last beat; the RTM bundle is driven from one register stage.
module rtm_wr_arb
  import rtm_wr_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int AW   = RTM_AW,
  parameter  int SW   = S,
  parameter  int DW   = RTM_DW,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  rtm_wr_arb_if.slave   bus,
  output logic [GW-1:0] grant_id,
  output logic          busy
);

  arb_state_e           state_r;
  logic [GW-1:0]        owner_r;
  logic [GW-1:0]        rr_r;

  logic [NREQ-1:0]      pick_gnt_s;
  logic                 pick_any_s;
  logic [NREQ-1:0]      rdy_s;
  logic [NREQ-1:0]      hits_s;
  logic                 acc_s;
  logic                 acc_last_s;
  logic [GW-1:0]        acc_idx_s;

  logic [SW-1:0]        en_a_s   [NREQ];
  logic [SW*AW-1:0]     addr_a_s [NREQ];
  logic [DW-1:0]        din_a_s  [NREQ];

  rtm_wr_arb_rr_pick #(.N(NREQ), .BW(GW)) u_pick (
    .req  (bus.req_vld),
    .base (rr_r),
    .gnt  (pick_gnt_s),
    .any  (pick_any_s)
  );

  // Ready: zero-bubble round-robin pick when idle, owner-only pass-through when locked.
  always_comb begin
    rdy_s = {NREQ{1'b0}};
    case (state_r)
      ARB_IDLE: rdy_s = pick_any_s ? pick_gnt_s : {NREQ{1'b0}};
      ARB_LOCK: rdy_s[owner_r] = bus.req_vld[owner_r];
      default:  rdy_s = {NREQ{1'b0}};
    endcase
  end

  assign bus.req_rdy = rdy_s;
  assign hits_s      = rdy_s & bus.req_vld;
  assign acc_s       = |hits_s;
  assign acc_last_s  = |(hits_s & bus.req_last);

  // hits_s is at most one-hot, so each index bit is an OR over the matching positions.
  for (genvar b = 0; b < GW; b++) begin : g_enc
    logic [NREQ-1:0] mask_s;
    for (genvar g = 0; g < NREQ; g++) begin : g_bit
      assign mask_s[g] = 1'((g >> b) & 1);
    end
    assign acc_idx_s[b] = |(hits_s & mask_s);
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign en_a_s[g]   = bus.req_en[g*SW +: SW];
    assign addr_a_s[g] = bus.req_addr[g*SW*AW +: SW*AW];
    assign din_a_s[g]  = bus.req_din[g*DW +: DW];
  end

  // Arbitration FSM with owner, round-robin base, grant id and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ARB_IDLE;
      owner_r  <= {GW{1'b0}};
      rr_r     <= {GW{1'b0}};
      grant_id <= {GW{1'b0}};
      busy     <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (acc_s) begin
            grant_id <= acc_idx_s;
            if (acc_last_s) begin
              rr_r <= GW'(rr_wrap(int'(acc_idx_s), NREQ));
            end else begin
              state_r <= ARB_LOCK;
              owner_r <= acc_idx_s;
              busy    <= 1'b1;
            end
          end
        end
        ARB_LOCK: begin
          if (acc_s && acc_last_s) begin
            state_r <= ARB_IDLE;
            busy    <= 1'b0;
            rr_r    <= GW'(rr_wrap(int'(owner_r), NREQ));
          end
        end
        default: begin
          state_r <= ARB_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // RTM output stage: always loads; address and data only move on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rtm_wr_vld  <= 1'b0;
      bus.rtm_wr_en   <= {SW{1'b0}};
      bus.rtm_wr_addr <= {(SW*AW){1'b0}};
      bus.rtm_din     <= {DW{1'b0}};
    end else begin
      bus.rtm_wr_vld <= acc_s;
      bus.rtm_wr_en  <= acc_s ? en_a_s[acc_idx_s] : {SW{1'b0}};
      if (acc_s) begin
        bus.rtm_wr_addr <= addr_a_s[acc_idx_s];
        bus.rtm_din     <= din_a_s[acc_idx_s];
      end
    end
  end

endmodule

// File: doc/rtm_wr_arb.md
# rtm_wr_arb

Round-robin, burst-locked arbiter that shares the RTM write port bundle (`rtm_wr_vld/en/addr/din`) between several write-back engines (FC write-back, conv write-back, DDR-to-RTM loader). Each requester presents write beats on a valid/ready handshake and marks the final beat of a burst with `last`. The arbiter grants one requester at a time, holds the grant until that requester's last beat, and drives the RTM write ports from a single output register stage.

## Interface
- `NREQ`, 2: number of requesters, ≥2.
- `AW`, `$clog2(RTM_DEPTH)`: RTM address width per slice.
- `SW`, `S`: number of RTM slices (write-enable width).
- `DW`, `S*R*8`: RTM data width.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_vld`  in  NREQ  per-requester beat valid.
- `req_rdy`  out  NREQ  per-requester beat accepted (combinational).
- `req_last`  in  NREQ  final beat of the burst.
- `req_en`  in  NREQ*SW  per-requester slice enables.
- `req_addr`  in  NREQ*SW*AW  per-requester slice addresses.
- `req_din`  in  NREQ*DW  per-requester write data.
- `rtm_wr_vld`  out  1  registered RTM write valid.
- `rtm_wr_en`  out  SW  registered slice enables.
- `rtm_wr_addr`  out  SW*AW  registered addresses.
- `rtm_din`  out  DW  registered write data.
- `grant_id`  out  $clog2(NREQ)  current or last owner.
- `busy`  out  1  high in LOCK state.

## Operation
- FSM has two states:
  - IDLE: no owner.
  - LOCK: owner holds the port, `owner` register is valid.
- Round-robin pointer `rr`:
  - Search order is `rr, rr+1, …, NREQ-1, 0, …`.
  - Winner is the first i with `req_vld[i]`.
- In IDLE, the winner w gets `req_rdy[w]=1` in the same cycle (zero-bubble grant), and its beat is accepted.
  - Beat has `req_last` low: go to LOCK, `owner<=w`, `grant_id<=w`.
  - Beat has `req_last` high (single-beat burst): stay IDLE, `rr<=w+1 mod NREQ`, `grant_id<=w`.
- In LOCK, only `req_rdy[owner]` can be high; it equals `req_vld[owner]`. All other `req_rdy` are 0.
- Accepting the owner's beat with `req_last` high returns to IDLE with `rr<=owner+1 mod NREQ`.
- Owner deasserting `req_vld` mid-burst holds the lock. No other requester is interleaved and no timeout applies.
- A beat is accepted when `req_vld[i] && req_rdy[i]`.
- On accept, the next cycle drives:
  - `rtm_wr_vld=1`
  - `rtm_wr_en=req_en[i]`
  - `rtm_wr_addr=req_addr[i]`
  - `rtm_din=req_din[i]`
- With no accept, the next cycle drives `rtm_wr_vld=0` and `rtm_wr_en=0`. Address and data hold their previous values.
- RTM has no backpressure, so the output register always loads.
- `req_en`, `req_addr` and `req_din` of the accepted requester are passed through unmodified. No address arithmetic is done in this block.

## Timing
- Reset values: `rtm_wr_vld=0`, `rtm_wr_en=0`, `rtm_wr_addr=0`, `rtm_din=0`, `grant_id=0`, `busy=0`, `rr=0`, state IDLE.
- Reset asserted mid-burst:
  - Immediately returns to IDLE and clears the outputs.
  - The partial burst is lost; requesters are reset by the same `rst_n`.
- Latency from accept to RTM write is 1 cycle.
- Throughput is one beat per cycle within a burst.
- Burst-to-burst: a requester waiting while another's last beat is accepted is granted in the following cycle (one-cycle IDLE evaluation). That IDLE cycle itself grants, so there is no dead cycle when a new `req_vld` is already high.
- `req_rdy` depends combinationally on `req_vld`, state, `owner` and `rr`. Requesters must not make `req_vld` depend on `req_rdy`.
- `busy` is registered and equals (state==LOCK).

## Structure
- Shared package / `incl.vh` provides:
  - `S`, `R`, `RTM_DEPTH` (already present).
  - State encodings `ARB_IDLE` and `ARB_LOCK`.
- Sub-module `rr_pick`:
  - Combinational rotate-priority-encoder over `NREQ` bits with base `rr`.
  - Outputs are the one-hot `gnt` and `any`.
  - Reusable by other codebase arbiters.
- Top level holds the FSM, the `rr`/`owner`/`grant_id` registers, the per-requester bundle mux, and the output register.

## Test plan
- Reset, then requester 0 sends a 4-beat burst at addr 10..13 with data 0xA0..0xA3:
  - `rtm_wr_vld` is high for 4 cycles, each one cycle after its accept.
  - Addresses and data match in order.
  - `busy` is high during beats 1-3, and `rr` ends at 1.
- Requesters 0 and 1 both assert valid at reset (`rr=0`), each with a 3-beat burst:
  - Requester 0 gets 3 beats, then requester 1 gets 3 beats.
  - No interleaving, and the RTM valid gap between bursts is ≤1 cycle.
- Requester 1 sends a single-beat burst (last=1), then requester 1 requests again while requester 0 is waiting:
  - Requester 0 is granted next (`rr=0` after wrap), state never enters LOCK for the single beat, and `grant_id=1` then 0.
- Owner 0 drops `req_vld` for 2 cycles mid-burst while requester 1 is valid:
  - `req_rdy[1]` stays 0, `rtm_wr_vld=0` and `rtm_wr_en=0` for those cycles.
  - Burst 0 then resumes and completes.
- `rst_n` pulsed low asynchronously during the beat-2 accept of a burst:
  - All outputs go 0 without waiting for a clock edge.
  - After release, a requester-1 burst is granted from IDLE with `rr=0` priority.
- Random traffic, `NREQ=4`, 10k cycles:
  - Scoreboard confirms every accepted beat is written exactly once, bursts are contiguous, and per-requester order is kept.
  - No requester waits longer than the sum of the other requesters' burst lengths.
